// File: rtl/bus_mem_responder_if.sv
// MainBus signals seen by the main-memory responder.
// Caches/bench drive requests through the master modport; the responder uses the slave side.
interface bus_mem_responder_if #(
  parameter int unsigned ADDRESSWIDTH = 16,
  parameter int unsigned DATABUSWIDTH = 32
);
  logic                    BusRd;
  logic                    BusUpd;
  logic                    BusFlush;
  logic [ADDRESSWIDTH-1:0] Address;
  logic [DATABUSWIDTH-1:0] DataIn;
  logic [DATABUSWIDTH-1:0] DataOut;
  logic                    DataOE;
  logic                    MemAck;
  logic                    Busy;
  logic                    ProtocolErr;

  modport master (
    output BusRd, BusUpd, BusFlush, Address, DataIn,
    input  DataOut, DataOE, MemAck, Busy, ProtocolErr
  );

  modport slave (
    input  BusRd, BusUpd, BusFlush, Address, DataIn,
    output DataOut, DataOE, MemAck, Busy, ProtocolErr
  );
endinterface

// File: rtl/bus_mem_responder.sv
// Main-memory responder on the snooping MainBus: fixed-latency block reads, one-cycle
// acknowledged writes, one transaction in flight, sticky protocol-error flag.
module bus_mem_responder #(
  parameter int unsigned ADDRESSWIDTH = 16,
  parameter int unsigned DATABUSWIDTH = 32,
  parameter int unsigned READ_LATENCY = 3
) (
  input  logic               clock,
  input  logic               reset,
  bus_mem_responder_if.slave bus
);
  localparam int unsigned IdxW  = ADDRESSWIDTH - 2;
  localparam int unsigned Words = 2 ** IdxW;
  localparam int unsigned ReqW  = ADDRESSWIDTH + 3;

  typedef enum logic [1:0] {StIdle, StRdWait, StRdDrive, StWrAck} state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic [IdxW-1:0]         rd_idx_q;
  logic [ReqW-1:0]         held_req_q;
  logic                    held_valid_q;
  logic [DATABUSWIDTH-1:0] data_out_q;
  logic                    data_oe_q;
  logic                    mem_ack_q;
  logic                    busy_q;
  logic                    prot_err_q;

  // Storage is deliberately outside the reset domain; contents survive reset.
  logic [DATABUSWIDTH-1:0] mem [Words] = '{default: '0};

  logic [IdxW-1:0] req_idx;
  logic [ReqW-1:0] req_vec;
  logic            wr_req;
  logic            any_req;
  logic            held_match;
  logic            wr_en;

  always_comb begin
    req_idx    = bus.Address[ADDRESSWIDTH-1:2];
    req_vec    = {bus.BusRd, bus.BusUpd, bus.BusFlush, bus.Address};
    wr_req     = bus.BusUpd | bus.BusFlush;
    any_req    = wr_req | bus.BusRd;
    held_match = held_valid_q && (req_vec == held_req_q);
    wr_en      = reset && (state_q == StIdle) && wr_req;
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[req_idx] <= bus.DataIn;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      rd_idx_q     <= '0;
      held_req_q   <= '0;
      held_valid_q <= 1'b0;
      data_out_q   <= '0;
      data_oe_q    <= 1'b0;
      mem_ack_q    <= 1'b0;
      busy_q       <= 1'b0;
      prot_err_q   <= 1'b0;
    end else begin
      mem_ack_q    <= 1'b0;
      data_oe_q    <= 1'b0;
      data_out_q   <= '0;
      held_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (wr_req) begin
            state_q      <= StWrAck;
            mem_ack_q    <= 1'b1;
            busy_q       <= 1'b1;
            held_req_q   <= req_vec;
            held_valid_q <= 1'b1;
            if (bus.BusRd) begin
              prot_err_q <= 1'b1;
            end
          end else if (bus.BusRd) begin
            rd_idx_q     <= req_idx;
            cnt_q        <= 4'(READ_LATENCY - 1);
            busy_q       <= 1'b1;
            held_req_q   <= req_vec;
            held_valid_q <= 1'b1;
            if (READ_LATENCY == 1) begin
              state_q    <= StRdDrive;
              data_out_q <= mem[req_idx];
              data_oe_q  <= 1'b1;
              mem_ack_q  <= 1'b1;
            end else begin
              state_q <= StRdWait;
            end
          end
        end
        StRdWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q    <= StRdDrive;
            data_out_q <= mem[rd_idx_q];
            data_oe_q  <= 1'b1;
            mem_ack_q  <= 1'b1;
          end
        end
        StRdDrive, StWrAck: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
      // A request left on the bus for one extra edge after acceptance is benign.
      if ((state_q != StIdle) && any_req && !held_match) begin
        prot_err_q <= 1'b1;
      end
    end
  end

  assign bus.DataOut     = data_out_q;
  assign bus.DataOE      = data_oe_q;
  assign bus.MemAck      = mem_ack_q;
  assign bus.Busy        = busy_q;
  assign bus.ProtocolErr = prot_err_q;
endmodule
